program_memory_ctrl: RTL
========================

Name: program_memory_ctrl

Overview:
- Parametrised, loadable successor to the fixed 128x16 instruction store.
- Programs are streamed in at run time through a word-serial load port; no file read happens inside the clock process.
- The CPU fetch stage reads the store with a registered, one-cycle request/valid handshake.
- Program length tracking, out-of-range detection and stop-bit (LSB=1) halt detection are handled in hardware.

Parameters:
- INSTR_W, 16: instruction width in bits.
- DEPTH, 128: number of instruction words.
- ADDR_W, $clog2(DEPTH): fetch address width.
- STOP_BIT, 0: bit index of the end-of-program marker inside an instruction.

Ports:
- clk, in, 1: system clock; all state updates on posedge.
- rst_n, in, 1: asynchronous, active-low reset.
- load_en, in, 1: pulse; starts a new program load.
- load_we, in, 1: during LOADING, writes load_data at the internal write pointer.
- load_data, in, INSTR_W: instruction word being loaded.
- load_done, in, 1: pulse; ends the load.
- load_ovf, out, 1: sticky; a write was attempted while the store was full; cleared by load_en.
- fetch_req, in, 1: fetch request.
- fetch_addr, in, ADDR_W: instruction address for the fetch.
- fetch_valid, out, 1: response strobe; exactly one cycle per accepted request.
- fetch_data, out, INSTR_W: fetched instruction; 0 on error.
- fetch_last, out, 1: fetched word has its STOP_BIT set.
- fetch_err, out, 1: fetch_addr >= prog_len.
- prog_len, out, ADDR_W+1: number of words loaded.
- ready, out, 1: state == READY.
- halted, out, 1: state == HALTED.
- restart, in, 1: pulse; HALTED -> READY without reloading.

Behaviour:
- Reset (async, rst_n=0):
  - state=EMPTY; wptr=0; prog_len=0.
  - Every output is 0.
  - Storage contents are not cleared.
- States:
  - EMPTY: load_en -> LOADING.
  - LOADING: load_done -> READY.
  - READY: a fetch response with fetch_last=1 -> HALTED, entered the cycle after that response. load_en -> LOADING.
  - HALTED: restart -> READY. load_en -> LOADING.
- load_en in any state:
  - Enters LOADING; wptr=0; load_ovf=0.
  - prog_len=0 on the next edge.
  - Takes priority over fetch_req, restart and load_done in the same cycle; a fetch dropped this way produces no response.
- LOADING:
  - load_we=1 and wptr<DEPTH: mem[wptr]<=load_data; wptr++.
  - load_we=1 and wptr==DEPTH: write dropped; load_ovf<=1.
  - load_done: prog_len<=wptr, counting a same-cycle write, which is performed. Then -> READY.
  - An empty load (load_done with no writes) gives prog_len=0; every fetch then errors.
- Fetch:
  - Accepted only in READY. In any other state fetch_req is ignored and fetch_valid stays 0.
  - Latency is 1: request at edge N, response registered and visible after edge N+1.
  - Back-to-back requests give back-to-back responses.
  - In-range (fetch_addr < prog_len): fetch_data=mem[fetch_addr]; fetch_last=fetch_data[STOP_BIT]; fetch_err=0.
  - Out-of-range: fetch_data=0; fetch_last=0; fetch_err=1; state unchanged.
  - All response outputs return to 0 in any cycle without a response.
- Halt:
  - After a fetch_last response the state becomes HALTED.
  - A request issued in that same response cycle is dropped (no response).
- restart outside HALTED is ignored.
- Reset mid-load: the load is abandoned; EMPTY with prog_len=0.
- Storage is synchronous-write/synchronous-read. A write and a read never coincide, because fetches are only accepted in READY.

Decomposition:
- Package pm_pkg holds:
  - state enum pm_state_t {EMPTY, LOADING, READY, HALTED};
  - default constants PM_INSTR_W=16, PM_DEPTH=128.
- Sub-module pm_storage holds the array: simple dual-port, one write port and one registered read port, parametrised on INSTR_W and DEPTH.
- The FSM, write pointer, length and range checks live in program_memory_ctrl.

Test Plan:
- Reset then fetch_req addr 0 -> no fetch_valid; ready=0; prog_len=0; all outputs 0.
- Load 13 words where word k = k<<1 and word 12 = 16'h0019; load_done -> prog_len=13; ready=1. Fetch addr 3 -> one cycle later valid=1, data=16'h0006, last=0, err=0.
- Fetch addr 12 -> data=16'h0019, last=1; halted=1 the next cycle. Fetch addr 0 -> no response. restart -> ready=1; fetch addr 0 -> data=0.
- In READY with prog_len=13, fetch addr 20 -> valid=1, err=1, data=0; state stays READY.
- Load with DEPTH=4: 6 writes then load_done -> prog_len=4; load_ovf=1. A new load_en clears load_ovf.
- In READY, load_en together with fetch_req -> no response; LOADING entered. Assert rst_n=0 after 2 writes -> EMPTY, prog_len=0.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared types and default sizes for the loadable program memory.
package pm_pkg;

  localparam int PM_INSTR_W = 16;
  localparam int PM_DEPTH   = 128;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    HALTED  = 2'd3
  } pm_state_t;

endpackage

// File: rtl/pm_storage.sv
// Instruction array: one write port, one registered read port.
// Contents are deliberately not reset.
module pm_storage #(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Synchronous write and synchronous registered read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/program_memory_ctrl.sv
// Loadable instruction store with a one-cycle fetch port.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   EMPTY   | nothing loaded since reset
//   LOADING | words streaming in at wptr
//   READY   | fetches accepted
//   HALTED  | a stop-bit word was fetched; waiting for restart
module program_memory_ctrl
  import pm_pkg::*;
#(
  parameter int INSTR_W  = PM_INSTR_W,
  parameter int DEPTH    = PM_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int STOP_BIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic               load_we,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_done,
  output logic               load_ovf,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_data,
  output logic               fetch_last,
  output logic               fetch_err,
  output logic [ADDR_W:0]    prog_len,
  output logic               ready,
  output logic               halted,
  input  logic               restart
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  pm_state_t          state;
  logic [ADDR_W:0]    wptr;
  logic               resp_valid;
  logic               resp_err;
  logic [INSTR_W-1:0] rd_data;

  logic wr_full;
  logic wr_en;
  logic in_range;
  logic halt_now;
  logic fetch_acc;
  logic rd_en;

  assign wr_full   = (wptr == DEPTH_L);
  assign wr_en     = (state == LOADING) && !load_en && load_we && !wr_full;
  assign in_range  = ({1'b0, fetch_addr} < prog_len);
  // A stop-bit response blocks any request in the same cycle.
  assign halt_now  = resp_valid && fetch_last;
  assign fetch_acc = (state == READY) && fetch_req && !load_en && !halt_now;
  assign rd_en     = fetch_acc && in_range;

  // The read register holds stale data between responses, so gate it.
  assign fetch_valid = resp_valid;
  assign fetch_err   = resp_err;
  assign fetch_data  = (resp_valid && !resp_err) ? rd_data : '0;
  assign fetch_last  = fetch_data[STOP_BIT];
  assign ready       = (state == READY);
  assign halted      = (state == HALTED);

  pm_storage #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (fetch_addr),
    .rdata (rd_data)
  );

  // State machine, write pointer, length tracking and fetch response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      wptr       <= '0;
      prog_len   <= '0;
      load_ovf   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= fetch_acc;
      resp_err   <= fetch_acc && !in_range;
      if (load_en) begin
        state    <= LOADING;
        wptr     <= '0;
        prog_len <= '0;
        load_ovf <= 1'b0;
      end else begin
        case (state)
          LOADING: begin
            if (load_we) begin
              if (wr_full) load_ovf <= 1'b1;
              else         wptr     <= wptr + 1'b1;
            end
            if (load_done) begin
              prog_len <= wptr + {{ADDR_W{1'b0}}, wr_en};
              state    <= READY;
            end
          end
          READY:   if (halt_now) state <= HALTED;
          HALTED:  if (restart)  state <= READY;
          default: ;
        endcase
      end
    end
  end

endmodule
